// File: rtl/network_can_nios2_oci_dct_sequencer_pkg.sv
// network_can_oci_dct_pkg: widths and FSM states shared by the DCT trace sequencer.
package network_can_oci_dct_pkg;
  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = ATOM_W * DEPTH;
  localparam int CNT_W  = 4;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;
endpackage

// File: rtl/network_can_nios2_oci_dct_sequencer_outreg.sv
// network_can_oci_dct_outreg: valid/ready output register that loads, holds and clears a trace word.
module network_can_oci_dct_outreg
  import network_can_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   out_ready,
  input  logic [CNT_W+BUF_W-1:0] data,
  output logic                   out_valid,
  output logic [CNT_W+BUF_W-1:0] out_word
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      if (load) out_word <= data;
      out_valid <= load | (out_valid & ~out_ready);
    end
endmodule

// File: rtl/network_can_nios2_oci_dct_sequencer.sv
// network_can_nios2_oci_dct_sequencer: packs 2-bit DCT atoms into 30-bit words and drains them at end of test.
module network_can_nios2_oci_dct_sequencer
  import network_can_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   atom_valid,
  input  logic [ATOM_W-1:0]      atom_data,
  output logic                   atom_ready,
  input  logic                   flush_req,
  input  logic                   test_ending,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W+BUF_W-1:0] out_word,
  output logic [BUF_W-1:0]       dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   test_has_ended,
  output logic [DROP_W-1:0]      drop_count
);
  state_t state, state_n;
  logic flush_pend, out_free, xfer, accept, pend_set;
  assign out_free       = !out_valid || out_ready;
  assign xfer           = out_free && (dct_count == CNT_W'(DEPTH) || (flush_pend && dct_count != '0));
  // held low during reset so every output reads 0 while reset_n is asserted
  assign atom_ready     = reset_n && dct_count < CNT_W'(DEPTH) && !xfer && state == RUN;
  assign accept         = atom_valid && atom_ready;
  assign pend_set       = (state != ENDED && flush_req) || (state == RUN && test_ending);
  assign test_has_ended = state == ENDED;
  always_comb begin
    state_n = state;
    state_n = (state == RUN && test_ending) ? DRAIN :
              (state == DRAIN && dct_count == '0 && !out_valid) ? ENDED : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      flush_pend <= pend_set ? 1'b1 : (xfer || dct_count == '0) ? 1'b0 : flush_pend;
      if (xfer) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else if (accept) begin
        dct_buffer[ATOM_W*int'(dct_count) +: ATOM_W] <= atom_data;
        dct_count <= dct_count + CNT_W'(1);
      end
      if (atom_valid && !atom_ready && state != ENDED && drop_count != '1)
        drop_count <= drop_count + DROP_W'(1);
    end
  network_can_oci_dct_outreg u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (xfer),
    .out_ready (out_ready),
    .data      ({dct_count, dct_buffer}),
    .out_valid (out_valid),
    .out_word  (out_word)
  );
endmodule

// File: tb/tb_network_can_nios2_oci_dct_sequencer.sv
// tb_network_can_nios2_oci_dct_sequencer: directed tables plus randomized traffic against a queue-based model.
module tb_network_can_nios2_oci_dct_sequencer;
  logic        clk = 0, reset_n = 1, atom_valid = 0, flush_req = 0, test_ending = 0, out_ready = 0;
  logic [1:0]  atom_data = 0;
  logic        atom_ready, out_valid, test_has_ended;
  logic [33:0] out_word;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_count;
  network_can_nios2_oci_dct_sequencer dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_data(atom_data),
    .atom_ready(atom_ready), .flush_req(flush_req), .test_ending(test_ending),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int mq[$];
  bit m_ov, m_fp;
  logic [33:0] m_ow;
  int m_ph, m_drop;
  typedef struct {
    bit v; logic [1:0] d; bit fl; bit te; bit rdy;
    int e_cnt; logic [29:0] e_buf; bit e_ov; logic [33:0] e_word;
  } vec_t;
  vec_t tbl[10];
  function automatic logic [29:0] m_buf();
    logic [29:0] b = '0;
    foreach (mq[i]) b = b | (30'(mq[i]) << (2 * i));
    return b;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(bit v, logic [1:0] d, bit fl, bit te, bit rdy);
    int cnt;
    bit free, xf, rd, set;
    atom_valid = v; atom_data = d; flush_req = fl; test_ending = te; out_ready = rdy;
    #3;
    cnt  = mq.size();
    free = !m_ov || rdy;
    xf   = free && (cnt == 15 || (m_fp && cnt > 0));
    rd   = cnt < 15 && !xf && m_ph == 0;
    chk("atom_ready", atom_ready, rd);
    chk("out_valid", out_valid, m_ov);
    chk("out_word", out_word, m_ow);
    chk("dct_buffer", dct_buffer, m_buf());
    chk("dct_count", dct_count, cnt);
    chk("test_has_ended", test_has_ended, m_ph == 2);
    chk("drop_count", drop_count, m_drop);
    if (v && !rd && m_ph != 2 && m_drop < 255) m_drop++;
    set  = (m_ph != 2 && fl) || (m_ph == 0 && te);
    m_fp = set ? 1'b1 : (xf || cnt == 0) ? 1'b0 : m_fp;
    if (m_ph == 0 && te) m_ph = 1;
    else if (m_ph == 1 && cnt == 0 && !m_ov) m_ph = 2;
    if (xf) begin
      m_ow = {4'(cnt), m_buf()};
      m_ov = 1;
      mq.delete();
    end else if (m_ov && rdy) m_ov = 0;
    if (v && rd) mq.push_back(int'(d));
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    atom_valid = 0; flush_req = 0; test_ending = 0; out_ready = 0;
    reset_n = 0;
    #1;
    chk("rst_atom_ready", atom_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_dct_count", dct_count, 0);
    chk("rst_test_has_ended", test_has_ended, 0);
    chk("rst_drop_count", drop_count, 0);
    mq.delete(); m_ov = 0; m_ow = '0; m_fp = 0; m_ph = 0; m_drop = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [1:0]  ad[15];
    logic [29:0] exp_buf;
    logic [3:0]  got_cnt;
    int          d0;
    tbl[0] = '{1, 2'd3, 0, 0, 1, 1, 30'h3,  0, 34'h0};
    tbl[1] = '{1, 2'd2, 0, 0, 1, 2, 30'hB,  0, 34'h0};
    tbl[2] = '{1, 2'd1, 0, 0, 1, 3, 30'h1B, 0, 34'h0};
    tbl[3] = '{0, 2'd0, 1, 0, 1, 3, 30'h1B, 0, 34'h0};
    tbl[4] = '{0, 2'd0, 0, 0, 1, 0, 30'h0,  1, {4'h3, 30'h1B}};
    tbl[5] = '{0, 2'd0, 0, 0, 1, 0, 30'h0,  0, 34'h0};
    tbl[6] = '{0, 2'd0, 0, 0, 1, 0, 30'h0,  0, 34'h0};
    tbl[7] = '{0, 2'd0, 1, 0, 1, 0, 30'h0,  0, 34'h0};
    tbl[8] = '{0, 2'd0, 0, 0, 1, 0, 30'h0,  0, 34'h0};
    tbl[9] = '{0, 2'd0, 0, 0, 1, 0, 30'h0,  0, 34'h0};
    #1;
    do_reset();
    // fifteen 01 atoms fill one word
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0, 1);
    chk("t1_count_full", dct_count, 15);
    step(0, 0, 0, 0, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_word", out_word, {4'hF, 30'h15555555});
    chk("t1_count_zero", dct_count, 0);
    step(0, 0, 0, 0, 1);
    chk("t1_valid_drop", out_valid, 0);
    // partial flush and empty flush
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].te, tbl[i].rdy);
      chk($sformatf("tbl%0d_cnt", i), dct_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_buf", i), dct_buffer, tbl[i].e_buf);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_word", i), out_word, tbl[i].e_word);
    end
    // back-pressure: 32 atoms with out_ready low
    do_reset();
    exp_buf = '0;
    for (int i = 0; i < 32; i++) begin
      d0 = $urandom_range(0, 3);
      if (i < 15) begin
        ad[i] = 2'(d0);
        exp_buf = exp_buf | (30'(d0) << (2 * i));
      end
      step(1, 2'(d0), 0, 0, 0);
    end
    chk("t4_count", dct_count, 15);
    chk("t4_atom_ready", atom_ready, 0);
    chk("t4_drop", drop_count, 2);
    chk("t4_valid", out_valid, 1);
    chk("t4_word_held", out_word, {4'hF, exp_buf});
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("t4_drained", dct_count, 0);
    // five atoms then end of test
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 0, 1);
    step(0, 0, 0, 1, 1);
    got_cnt = 0;
    for (int i = 0; i < 20 && !test_has_ended; i++) begin
      step(0, 0, 0, 0, 1);
      if (out_valid) got_cnt = out_word[33:30];
    end
    chk("t5_ended", test_has_ended, 1);
    chk("t5_word_count", got_cnt, 5);
    d0 = int'(drop_count);
    for (int i = 0; i < 4; i++) step(1, 2'd2, 1, 1, 1);
    chk("t5_drop_frozen", drop_count, d0);
    chk("t5_still_ended", test_has_ended, 1);
    // asynchronous reset with a pending word and a partial buffer
    do_reset();
    for (int i = 0; i < 16; i++) step(i < 15, 2'd3, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'd1, 0, 0, 0);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_count", dct_count, 7);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 2'd2, 0, 0, 1);
    chk("t6_resume_count", dct_count, 3);
    chk("t6_resume_buf", dct_buffer, 30'h2A);
    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
             i >= 250 && $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
